// File: rtl/uart_tx_controller.sv
// uart_tx_controller: 8N1 UART transmitter fed by a small byte FIFO.
// Frames are 1 start bit, 8 data bits LSB first, 1 stop bit; TX_DONE pulses after each.
module uart_tx_controller #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TX_WR,
    input  logic [7:0] TX_DATA,
    output logic       UART_TXD,
    output logic       TX_FULL,
    output logic       TX_BUSY,
    output logic       TX_DONE
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
    localparam logic [15:0]      LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] ONE   = (FIFO_AW + 1)'(1);
    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               done_q, done_d;
    logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic               push, pop;

    // A write while full is dropped even if the FSM pops in the same cycle.
    assign TX_FULL  = count_q == DEPTH;
    assign TX_BUSY  = state_q != IDLE || count_q != '0;
    assign push     = TX_WR && !TX_FULL;
    assign pop      = state_q == IDLE && count_q != '0;
    assign UART_TXD = txd_q;
    assign TX_DONE  = done_q;

    always_comb begin
        wp_d    = push ? wp_q + FIFO_AW'(1) : wp_q;
        rp_d    = pop ? rp_q + FIFO_AW'(1) : rp_q;
        count_d = (push && !pop) ? count_q + ONE : (pop && !push) ? count_q - ONE : count_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                txd_d   = !pop;
                shift_d = pop ? mem_q[rp_q] : shift_q;
                state_d = pop ? START : IDLE;
            end
            START: begin
                cnt_d   = cnt_q == LAST ? '0 : cnt_q + 16'd1;
                txd_d   = cnt_q == LAST ? shift_q[0] : 1'b0;
                state_d = cnt_q == LAST ? DATA : START;
            end
            DATA: begin
                cnt_d = cnt_q == LAST ? '0 : cnt_q + 16'd1;
                if (cnt_q == LAST) begin
                    idx_d   = idx_q == 3'd7 ? 3'd0 : idx_q + 3'd1;
                    txd_d   = idx_q == 3'd7 ? 1'b1 : shift_q[idx_q + 3'd1];
                    state_d = idx_q == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                txd_d   = 1'b1;
                cnt_d   = cnt_q == LAST ? '0 : cnt_q + 16'd1;
                state_d = cnt_q == LAST ? CLEANUP : STOP;
            end
            CLEANUP: begin
                txd_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; flushing the pointers and count empties the queue.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= TX_DATA;
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: directed and random checks of the UART transmitter.
// A line-level receiver model decodes frames and checks bit timing, gaps and TX_DONE.
module tb_uart_tx_controller;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr = 1'b0, wr_def = 1'b0;
    logic [7:0] data = '0, data_def = '0;
    logic txd, full, busy, done;
    logic txd_def, full_def, busy_def, done_def;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .TX_WR(wr), .TX_DATA(data),
        .UART_TXD(txd), .TX_FULL(full), .TX_BUSY(busy), .TX_DONE(done));

    uart_tx_controller dut_def (
        .clk(clk), .rst_n(rst_n), .TX_WR(wr_def), .TX_DATA(data_def),
        .UART_TXD(txd_def), .TX_FULL(full_def), .TX_BUSY(busy_def), .TX_DONE(done_def));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model: one sample per clock, 10 bits of CPB samples each.
    logic [39:0] smp;
    logic [7:0]  mon_byte;
    logic        mon_bad;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          gap_q[$];
    int ph = -1, hi_run = 0, cyc = 0, fall_cyc = 0, done_cnt = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ph = -1;
            hi_run = 0;
            prev_done = 1'b0;
        end else begin
            if (done === 1'b1) begin
                chk("done_latency", cyc - fall_cyc, 10 * CPB + 1);
                chk("done_width", prev_done, 0);
                done_cnt++;
            end
            prev_done = done;
            if (ph < 0) begin
                if (txd === 1'b0) begin
                    smp[0] = 1'b0;
                    ph = 1;
                    fall_cyc = cyc;
                    gap_q.push_back(hi_run);
                end else hi_run++;
            end else begin
                smp[ph] = txd;
                if (ph == 10 * CPB - 1) begin
                    mon_bad = 1'b0;
                    for (int b = 0; b < 10; b++)
                        for (int k = 1; k < CPB; k++)
                            if (smp[b * CPB + k] !== smp[b * CPB]) mon_bad = 1'b1;
                    chk("frame_shape", {29'd0, smp[0], smp[9 * CPB], mon_bad}, 32'b010);
                    for (int b = 0; b < 8; b++) mon_byte[b] = smp[(b + 1) * CPB];
                    rx_q.push_back(mon_byte);
                    ph = -1;
                    hi_run = CPB;
                end else ph++;
            end
        end
    end

    task automatic wait_frames(input string tag);
        int t = 0;
        while ((rx_q.size() < exp_q.size() || busy) && t < 60 * CPB * (exp_q.size() + 1)) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < rx_q.size()) chk({tag, "_byte"}, rx_q[i], exp_q[i]);
            if (i > 0 && i < gap_q.size()) chk({tag, "_gap"}, gap_q[i], CPB + 2);
        end
        rx_q.delete();
        exp_q.delete();
        gap_q.delete();
    endtask

    task automatic idle_watch(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || done !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        #1_500_000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] x;
        logic lvl;
        int n, t;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        idle_watch("idle_50", 50);

        // Single byte, data changed right after the write.
        @(negedge clk); wr = 1'b1; data = 8'hA5;
        @(negedge clk); wr = 1'b0; data = 8'hFF;
        chk("lat_pre_txd", txd, 1);
        chk("busy_after_wr", busy, 1);
        @(negedge clk);
        chk("lat_fall_txd", txd, 0);
        exp_q.push_back(8'hA5);
        n = done_cnt;
        wait_frames("single");
        chk("single_done_cnt", done_cnt - n, 1);

        // One byte goes straight to the shifter, four fill the queue, the sixth is dropped.
        n = done_cnt;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) chk("fill_not_full", full, 0);
            if (i == 6) chk("fill_full", full, 1);
            wr = 1'b1;
            data = 8'(i);
            if (i <= DEPTH + 1) exp_q.push_back(8'(i));
        end
        @(negedge clk); wr = 1'b0; data = 8'h00;
        chk("drop_full_stays", full, 1);
        wait_frames("fill");
        chk("fill_done_cnt", done_cnt - n, DEPTH + 1);

        // Write on the cycle the idle FSM pops from a full queue.
        n = done_cnt;
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk); wr = 1'b1; data = 8'($urandom);
            exp_q.push_back(data);
        end
        @(negedge clk); wr = 1'b0;
        chk("fp_full", full, 1);
        t = 0;
        while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk("fp_done_seen", done, 1);
        wr = 1'b1; data = 8'hEE;
        @(negedge clk); wr = 1'b0;
        chk("fp_drop_count", full, 0);
        x = 8'($urandom);
        wr = 1'b1; data = x;
        @(negedge clk); wr = 1'b0; data = 8'($urandom);
        chk("fp_refill_full", full, 1);
        exp_q.push_back(x);
        wait_frames("fullpop");
        chk("fp_done_cnt", done_cnt - n, DEPTH + 2);

        // Random bursts from idle: one byte in flight plus DEPTH queued, extras dropped.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                @(negedge clk); wr = 1'b1; data = 8'($urandom);
                if (i < DEPTH + 1) exp_q.push_back(data);
            end
            @(negedge clk); wr = 1'b0; data = 8'($urandom);
            wait_frames("rand");
        end

        // Reset in the middle of data bit 3 of 0x00.
        @(negedge clk); wr = 1'b1; data = 8'h00;
        @(negedge clk); wr = 1'b0; data = 8'hFF;
        repeat (4 * CPB + 2) @(negedge clk);
        chk("mid_txd_low", txd, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_txd", txd, 1);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_watch("post_rst_idle", 60);
        chk("post_rst_no_frame", rx_q.size(), 0);
        rx_q.delete();
        gap_q.delete();

        // Default bit time: 0x55 makes every bit through bit 7 toggle the line.
        @(negedge clk); wr_def = 1'b1; data_def = 8'h55;
        @(negedge clk); wr_def = 1'b0; data_def = 8'h00;
        @(negedge clk);
        chk("def_fall", txd_def, 0);
        t = 0;
        for (int r = 0; r < 9; r++) begin
            lvl = txd_def;
            n = 0;
            do begin @(negedge clk); n++; end while (txd_def === lvl && n < 6000);
            chk("def_bit_len", n, 5208);
            t += n;
        end
        n = 0;
        while (done_def !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
        chk("def_stop_level", txd_def, 1);
        chk("def_frame_len", t + n, 52081);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
